// File: rtl/sqrt_detect_ctrl_if.sv
// Control/status bundle between the sqrt detector controller and its datapath/host.
// master = controller side, slave = datapath + requester side.
interface sqrt_detect_ctrl_if;
  logic       go;
  logic       lt;
  logic       eq;
  logic       clr;
  logic       ld_sqrt;
  logic       ld_sum;
  logic       ld_val;
  logic [2:0] tx;
  logic [1:0] ty;
  logic [1:0] fn;
  logic       busy;
  logic       done;
  logic       is_square;
  logic       err;

  modport master (
    input  go, lt, eq,
    output clr, ld_sqrt, ld_sum, ld_val, tx, ty, fn, busy, done, is_square, err
  );

  modport slave (
    output go, lt, eq,
    input  clr, ld_sqrt, ld_sum, ld_val, tx, ty, fn, busy, done, is_square, err
  );
endinterface

// File: rtl/sqrt_detect_ctrl.sv
// Moore sequencer for the odd-number-accumulation perfect-square detector.
// Optional iteration timeout enabled by defining SQRT_CTRL_TIMEOUT_EN.
module sqrt_detect_ctrl #(
  parameter int MAX_ITER = 65536,
  parameter int ITER_W   = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sqrt_detect_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE, INIT, CHK0, ACC, INCR, CMP, ODD, DONE
  } state_e;

  localparam logic [2:0] TX_SUM  = 3'b100;
  localparam logic [2:0] TX_SQRT = 3'b010;
  localparam logic [2:0] TX_IN   = 3'b001;
  localparam logic [1:0] TY_VAL  = 2'b10;
  localparam logic [1:0] TY_SUM  = 2'b01;
  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_CMP  = 2'b01;
  localparam logic [1:0] FN_INC  = 2'b10;
  localparam logic [1:0] FN_INC2 = 2'b11;

  // The counter must be able to reach MAX_ITER-1.
  if (MAX_ITER >= (64'd1 << ITER_W)) begin : g_bad_cfg
    $error("sqrt_detect_ctrl: ITER_W too small for MAX_ITER");
  end

  state_e state_q, state_d;
  logic   is_sq_q, is_sq_d;
  logic   accept;
  logic   timeout_hit;

  assign accept = (state_q == IDLE) && bus.go;

`ifdef SQRT_CTRL_TIMEOUT_EN
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              err_q, err_d;

  assign timeout_hit = (iter_q == ITER_W'(MAX_ITER - 1));

  always_comb begin
    iter_d = iter_q;
    err_d  = err_q;
    if (accept) begin
      iter_d = '0;
      err_d  = 1'b0;
    end else if (state_q == ODD) begin
      iter_d = iter_q + 1'b1;
    end else if (state_q == CMP && !bus.eq && !bus.lt && timeout_hit) begin
      err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q <= '0;
      err_q  <= 1'b0;
    end else begin
      iter_q <= iter_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      is_sq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sq_q <= is_sq_d;
    end
  end

  // eq wins over lt if the datapath ever raises both.
  always_comb begin
    state_d = state_q;
    is_sq_d = is_sq_q;
    unique case (state_q)
      IDLE: if (bus.go) begin
        state_d = INIT;
        is_sq_d = 1'b0;
      end
      INIT: state_d = CHK0;
      CHK0: if (bus.eq) begin
        is_sq_d = 1'b1;
        state_d = DONE;
      end else begin
        state_d = ACC;
      end
      ACC:  state_d = INCR;
      INCR: state_d = CMP;
      CMP: begin
        if (bus.eq) begin
          is_sq_d = 1'b1;
          state_d = DONE;
        end else if (bus.lt || timeout_hit) begin
          is_sq_d = 1'b0;
          state_d = DONE;
        end else begin
          state_d = ODD;
        end
      end
      ODD:  state_d = ACC;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.clr     = 1'b0;
    bus.ld_sqrt = 1'b0;
    bus.ld_sum  = 1'b0;
    bus.ld_val  = 1'b0;
    bus.tx      = 3'b000;
    bus.ty      = 2'b00;
    bus.fn      = FN_ADD;
    bus.busy    = 1'b1;
    bus.done    = 1'b0;
    unique case (state_q)
      IDLE: bus.busy = 1'b0;
      INIT: bus.clr  = 1'b1;
      CHK0, CMP: begin
        bus.tx = TX_IN;
        bus.ty = TY_SUM;
        bus.fn = FN_CMP;
      end
      ACC: begin
        bus.tx     = TX_SUM;
        bus.ty     = TY_VAL;
        bus.fn     = FN_ADD;
        bus.ld_sum = 1'b1;
      end
      INCR: begin
        bus.tx      = TX_SQRT;
        bus.fn      = FN_INC;
        bus.ld_sqrt = 1'b1;
      end
      ODD: begin
        bus.ty     = TY_VAL;
        bus.fn     = FN_INC2;
        bus.ld_val = 1'b1;
      end
      DONE: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
      end
      default: bus.busy = 1'b0;
    endcase
  end

  assign bus.is_square = is_sq_q;

endmodule

// File: tb/tb_sqrt_detect_ctrl.sv
// Directed bench for sqrt_detect_ctrl with a behavioural sqrt/sum/val datapath.
// Build with SQRT_CTRL_TIMEOUT_EN to exercise the iteration timeout (MAX_ITER=4).
module tb_sqrt_detect_ctrl;

`ifdef SQRT_CTRL_TIMEOUT_EN
  localparam int TB_MAX_ITER = 4;
`else
  localparam int TB_MAX_ITER = 65536;
`endif
  localparam int LIMIT = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sqrt_detect_ctrl_if bus ();

  sqrt_detect_ctrl #(.MAX_ITER(TB_MAX_ITER), .ITER_W(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] din = '0;
  logic [31:0] dp_sqrt = '0, dp_sum = '0, dp_val = '0;
  logic [31:0] xb, yb, alu;

  always_comb begin
    xb = '0;
    if (bus.tx[2])      xb = dp_sum;
    else if (bus.tx[1]) xb = dp_sqrt;
    else if (bus.tx[0]) xb = din;
    yb = '0;
    if (bus.ty[1])      yb = dp_val;
    else if (bus.ty[0]) yb = dp_sum;
    case (bus.fn)
      2'b00:   alu = xb + yb;
      2'b01:   alu = xb;
      2'b10:   alu = xb + 1;
      default: alu = yb + 2;
    endcase
  end

  assign bus.lt = (xb < yb);
  assign bus.eq = (xb == yb);

  always @(posedge clk) begin
    if (bus.clr) begin
      dp_sqrt <= '0;
      dp_sum  <= '0;
      dp_val  <= 32'd1;
    end else begin
      if (bus.ld_sqrt) dp_sqrt <= alu;
      if (bus.ld_sum)  dp_sum  <= alu;
      if (bus.ld_val)  dp_val  <= alu;
    end
  end

  // Per-cycle bus legality and strobe accounting.
  int strb_cyc = 0, ld_cyc = 0, bad_cyc = 0, done_cnt = 0;
  always @(negedge clk) begin
    if ($countones(bus.tx) > 1 || $countones(bus.ty) > 1 ||
        $countones({bus.clr, bus.ld_sqrt, bus.ld_sum, bus.ld_val}) > 1)
      bad_cyc <= bad_cyc + 1;
    if (bus.clr | bus.ld_sqrt | bus.ld_sum | bus.ld_val) strb_cyc <= strb_cyc + 1;
    if (bus.ld_sqrt | bus.ld_sum | bus.ld_val) ld_cyc <= ld_cyc + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({bus.clr, bus.ld_sqrt, bus.ld_sum, bus.ld_val, bus.tx, bus.ty,
                 bus.fn, bus.busy, bus.done, bus.is_square, bus.err});
  endfunction

  // Call just after edge 0; returns the edge that closes the done cycle, -1 on timeout.
  task automatic wait_done(output int edge_no);
    edge_no = -1;
    for (int i = 1; i <= LIMIT; i++) begin
      @(negedge clk);
      if (bus.done) begin
        edge_no = i;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic run(input string nm, input logic [31:0] v, input int exp_edge,
                     input int exp_sq, input int exp_err, input int exp_root,
                     input int exp_strb, input int exp_ld);
    int e, s0, l0, b0;
    @(negedge clk);
    din = v;
    bus.go = 1'b1;
    s0 = strb_cyc; l0 = ld_cyc; b0 = bad_cyc;
    @(posedge clk);
    #1 bus.go = 1'b0;
    wait_done(e);
    chk({nm, "_done_edge"}, e, exp_edge);
    if (e > 0) begin
      chk({nm, "_is_square"}, int'(bus.is_square), exp_sq);
      chk({nm, "_err"}, int'(bus.err), exp_err);
      chk({nm, "_sqrt_reg"}, int'(dp_sqrt), exp_root);
      chk({nm, "_busy_in_done"}, int'(bus.busy), 0);
      chk({nm, "_strobe_cycles"}, strb_cyc - s0, exp_strb);
      chk({nm, "_ld_cycles"}, ld_cyc - l0, exp_ld);
      chk({nm, "_bus_legal"}, bad_cyc - b0, 0);
    end
    @(posedge clk);
    #1 chk({nm, "_done_one_cycle"}, int'(bus.done), 0);
    chk({nm, "_result_held"}, int'(bus.is_square), exp_sq);
  endtask

  initial begin
    int e, d0;
    bus.go = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", all_outs(), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("idle_outputs", all_outs(), 0);

    run("in16", 32'd16, 18, 1, 0, 4, 12, 11);
    run("in15", 32'd15, 18, 0, 0, 4, 12, 11);
    run("in0",  32'd0,   3, 1, 0, 0,  1,  0);
    run("in1",  32'd1,   6, 1, 0, 1,  3,  2);
`ifdef SQRT_CTRL_TIMEOUT_EN
    run("in100_timeout", 32'd100, 18, 0, 1, 4, 12, 11);
    run("in4_after_timeout", 32'd4, 10, 1, 0, 2, 6, 5);
`else
    run("in100", 32'd100, 42, 1, 0, 10, 30, 29);
`endif

    // go held high: one run, then re-accepted right after done.
    @(negedge clk);
    din = 32'd9;
    bus.go = 1'b1;
    @(posedge clk);
    wait_done(e);
    chk("hold_go_done_edge", e, 14);
    chk("hold_go_is_square", int'(bus.is_square), 1);
    @(posedge clk);
    #1 chk("hold_go_idle_after_done", int'(bus.busy), 0);
    chk("hold_go_no_second_done", int'(bus.done), 0);
    @(posedge clk);
    #1 chk("hold_go_restart", int'(bus.busy), 1);
    bus.go = 1'b0;
    wait_done(e);
    chk("hold_go_second_edge", e, 14);
    chk("hold_go_second_root", int'(dp_sqrt), 3);

    // Asynchronous reset in the middle of an in=9 run.
    @(negedge clk);
    din = 32'd9;
    bus.go = 1'b1;
    @(posedge clk);
    #1 bus.go = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("pre_reset_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 0);
    d0 = done_cnt;
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 chk("reset_no_done", done_cnt - d0, 0);
    chk("reset_stays_idle", all_outs(), 0);

    run("in4_after_reset", 32'd4, 10, 1, 0, 2, 6, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
